req_arbiter: RTL and testbench
==============================

REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter N, default 8: number of request lines, power of two, >= 2.
REQ-002 Parameter W, default 3: index width, equal to log2(N).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset; clock clk.
REQ-005 req  input  N  level request lines, one per requester; bit i is requester i.
REQ-006 out_ready  input  1  downstream consumer accepts the current grant.
REQ-007 out_valid  output  1  grant and grant_idx are valid.
REQ-008 grant  output  N  registered one-hot grant; all zero when out_valid=0.
REQ-009 grant_idx  output  W  binary index of the set bit of grant; downstream decoder input.
REQ-010 ptr  output  W  current round-robin priority pointer, for debug and verification.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 Arbitration rule: select the first set bit of req scanning from index ptr upward, wrapping from N-1 to 0; ptr has highest priority.
REQ-013 IDLE, req=0: remain in IDLE, out_valid=0, grant=0.
REQ-014 IDLE, req!=0: register the winner at the clock edge, enter GRANT, out_valid=1 from the next cycle (1-cycle request-to-grant latency).
REQ-015 GRANT: grant and grant_idx SHALL hold stable while out_ready=0, regardless of changes on req, including deassertion of the granted bit (no revocation).
REQ-016 Handshake = out_valid & out_ready, sampled at the rising edge.
REQ-017 On handshake, ptr SHALL become (grant_idx+1) mod N, wrapping from N-1 to 0.
REQ-018 On handshake with req!=0 that cycle, the block SHALL arbitrate in the same cycle using the updated pointer (grant_idx+1) and stay in GRANT with the new winner, giving back-to-back grants at 1 per cycle.
REQ-019 On handshake with req=0, the block SHALL enter IDLE; out_valid=0 and grant=0 from the next cycle.
REQ-020 ptr SHALL change only on handshake or reset.
REQ-021 grant SHALL always equal the one-hot decode of grant_idx when out_valid=1; at most one grant bit is ever set.
REQ-022 out_ready while out_valid=0 SHALL be ignored.
REQ-023 Requesters SHALL keep req asserted until granted; a single requester with req held continuously is re-granted only after every other active requester has been served once (fairness bound: N grants).

Reset
REQ-024 While rst=1, asynchronously and without waiting for a clock edge: state=IDLE, ptr=0, out_valid=0, grant=0, grant_idx=0.
REQ-025 Reset asserted mid-GRANT SHALL drop the pending grant with no handshake; arbitration after release SHALL restart from ptr=0.
REQ-026 The first arbitration SHALL occur at the first rising edge after rst deasserts at which req!=0.

Verification
REQ-027 After reset, req=8'b0010_0000, out_ready=1 -> next cycle out_valid=1, grant=8'b0010_0000, grant_idx=5; after the handshake ptr=6.
REQ-028 req=8'hFF held, out_ready=1 held -> grant_idx sequence 0,1,2,...,7,0,1 on consecutive cycles, with out_valid continuously 1.
REQ-029 Backpressure: grant_idx=3 pending, out_ready=0 for 5 cycles while req toggles to 8'h00 then 8'hF0 -> grant=8'b0000_1000 and grant_idx=3 stable all 5 cycles; after out_ready=1, next grant_idx=4.
REQ-030 Wrap: ptr=6, req=8'b0000_0011 -> grant_idx=0; after handshake ptr=1 and next grant_idx=1.
REQ-031 rst pulsed while out_valid=1, grant_idx=4 -> out_valid, grant and grant_idx are 0 during reset; after release with req=8'b1001_0000 -> grant_idx=4 (ptr=0).
REQ-032 Handshake with req=0 -> out_valid=0 next cycle; ptr holds the updated value; the FSM stays in IDLE until req!=0.

Source files
------------

// File: rtl/req_arbiter.sv
// Round-robin request arbiter with a valid/ready grant handshake.
// The winner is registered: one-hot grant plus its binary index, held
// stable until the consumer accepts it. The pointer moves to just past the
// accepted index, which gives each active requester a turn within N grants.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no grant outstanding; arbitrate from ptr when any req is set
// S_GRANT| grant held until out_ready; on accept, re-arbitrate at once
module req_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic [W-1:0] ptr
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [N-1:0]   grant_q, grant_d;

    logic           handshake;
    logic [W-1:0]   scan_base;
    logic [W-1:0]   cand;
    logic           win_found;
    logic [W-1:0]   win_idx;

    // Priority scan starting at scan_base. The base is the post-accept
    // pointer during a handshake so back-to-back grants already use the
    // updated priority. Scanning high offset to low lets the nearest hit win.
    always_comb begin
        handshake = (state_q == S_GRANT) && out_ready;
        scan_base = handshake ? (idx_q + W'(1)) : ptr_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = scan_base + W'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-grant logic; out_ready is only meaningful in S_GRANT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    idx_d   = win_idx;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
                end
            end
            S_GRANT: begin
                if (handshake) begin
                    ptr_d = idx_q + W'(1);
                    if (win_found) begin
                        idx_d   = win_idx;
                        grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    // State, pointer and grant registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
        end
    end

    assign out_valid = (state_q == S_GRANT);
    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed-vector bench for req_arbiter (N=8): a table of per-cycle inputs
// and hand-computed outputs, plus a hand-written asynchronous reset sequence.
module tb_req_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic [2:0] ptr;

    int checks   = 0;
    int failures = 0;

    req_arbiter #(.N(8), .W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .ptr       (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rdy;
        logic       v;
        logic [7:0] g;
        logic [2:0] idx;
        logic [2:0] p;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] rq, input logic rd,
                       input logic v, input logic [7:0] g, input logic [2:0] idx,
                       input logic [2:0] p, input string name);
        vec_t e;
        e.rst = r; e.req = rq; e.rdy = rd;
        e.v = v; e.g = g; e.idx = idx; e.p = p; e.name = name;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic v, input logic [7:0] g,
                             input logic [2:0] idx, input logic [2:0] p);
        check({name, ".out_valid"}, 32'(out_valid), 32'(v));
        check({name, ".grant"},     32'(grant),     32'(g));
        check({name, ".grant_idx"}, 32'(grant_idx), 32'(idx));
        check({name, ".ptr"},       32'(ptr),       32'(p));
    endtask

    initial begin
        // single request after reset, then handshake with no request -> idle
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, "idle_no_req");
        add(0, 8'h20, 1, 1, 8'h20, 5, 0, "first_grant5");
        add(0, 8'h00, 1, 0, 8'h00, 0, 6, "hs_to_idle");
        add(0, 8'h00, 1, 0, 8'h00, 0, 6, "ready_ignored_idle");
        // wrap: ptr=6, req=0000_0011
        add(0, 8'h03, 0, 1, 8'h01, 0, 6, "wrap_grant0");
        add(0, 8'h03, 1, 1, 8'h02, 1, 1, "wrap_next1");
        add(0, 8'h00, 1, 0, 8'h00, 0, 2, "wrap_idle");
        // full load from ptr=0
        add(1, 8'h00, 0, 0, 8'h00, 0, 0, "reset_mid");
        for (int k = 0; k < 10; k++)
            add(0, 8'hFF, 1, 1, 8'h01 << (k % 8), 3'(k % 8), 3'(k % 8), "rr_all");
        // backpressure with grant_idx=3 pending
        add(0, 8'h08, 1, 1, 8'h08, 3, 2, "bp_grant3");
        add(0, 8'h00, 0, 1, 8'h08, 3, 2, "bp_hold_a");
        add(0, 8'h00, 0, 1, 8'h08, 3, 2, "bp_hold_b");
        add(0, 8'hF0, 0, 1, 8'h08, 3, 2, "bp_hold_c");
        add(0, 8'hF0, 0, 1, 8'h08, 3, 2, "bp_hold_d");
        add(0, 8'hF0, 0, 1, 8'h08, 3, 2, "bp_hold_e");
        add(0, 8'hF0, 1, 1, 8'h10, 4, 4, "bp_release4");
        add(0, 8'hF0, 1, 1, 8'h20, 5, 5, "next5");
        add(0, 8'h10, 1, 1, 8'h10, 4, 6, "wrap_back4");
        add(0, 8'h10, 0, 1, 8'h10, 4, 6, "hold4");

        rst = 1'b1; req = 8'h00; out_ready = 1'b0;
        #1;
        check_all("por_async", 0, 8'h00, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all("por_clocked", 0, 8'h00, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; req = tbl[i].req; out_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            check_all($sformatf("%s[%0d]", tbl[i].name, i), tbl[i].v, tbl[i].g,
                      tbl[i].idx, tbl[i].p);
        end

        // asynchronous reset while grant_idx=4 is pending, ptr=6
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all("rst_async_drop", 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        check_all("rst_held", 0, 8'h00, 0, 0);
        @(negedge clk);
        rst = 1'b0; req = 8'h90; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst_grant4", 1, 8'h10, 4, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst_next7", 1, 8'h80, 7, 5);
        @(negedge clk);
        req = 8'h00;
        @(posedge clk);
        #1;
        check_all("post_rst_idle", 0, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
